// File: rtl/wb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// wb_pipe_pkg
// Shared definitions for the write-back stage: result-select encodings, the
// stage FSM state enum, flag bit positions inside the 4-bit {O,S,C,Z} vector,
// and a helper that packs the individual ALU flags into that vector.
// -----------------------------------------------------------------------------
package wb_pipe_pkg;

    // Result-select encodings driven on uc_S_MXRB.
    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_MEM = 2'b01,
        SEL_PC  = 2'b10,
        SEL_IMM = 2'b11
    } sel_e;

    // Write-back stage FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_COMMIT   = 2'b10
    } state_e;

    // Flag bit indices within the packed flag vector.
    localparam int FLAG_O = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    // Width of the memory-wait counter; wide enough for TIMEOUT up to 255.
    localparam int CNT_W = 8;

    function automatic logic [3:0] pack_flags(input logic o, input logic s,
                                              input logic c, input logic z);
        logic [3:0] r;
        r         = '0;
        r[FLAG_O] = o;
        r[FLAG_S] = s;
        r[FLAG_C] = c;
        r[FLAG_Z] = z;
        return r;
    endfunction

endpackage

// File: rtl/wb_flag_reg.sv
// -----------------------------------------------------------------------------
// wb_flag_reg
// Architectural {O,S,C,Z} flag register with a per-bit write mask.
// Bits selected by mask_i take d_i when we_i is high; all other bits hold.
// Ports:
//   clk_i   in  1  rising-edge clock
//   rst_ni  in  1  asynchronous active-low reset (clears all flags)
//   we_i    in  1  write enable
//   mask_i  in  4  per-bit write mask
//   d_i     in  4  new flag values
//   q_o     out 4  current flag values
// -----------------------------------------------------------------------------
module wb_flag_reg
    import wb_pipe_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       we_i,
    input  logic [3:0] mask_i,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (we_i) begin
            flags_d = (flags_q & ~mask_i) | (d_i & mask_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign q_o = flags_q;

endmodule

// File: rtl/wb_pipe.sv
// -----------------------------------------------------------------------------
// wb_pipe
// Write-back pipeline stage. Accepts one op per cycle, selects the write-back
// value (ALU / memory / link PC / immediate), waits for the data memory on
// loads (with a timeout that drops the op and raises a sticky error), and
// commits the register write and masked flag update in a single COMMIT cycle.
//
// Handshake: an op transfers on a rising edge where in_valid && in_ready.
// in_ready is high in IDLE and COMMIT and low in WAIT_MEM; in_ready does not
// depend on in_valid. dm_valid is a single-cycle response strobe, only
// observed in WAIT_MEM.
//
// Ports:
//   CLK, RST_N                  clock, async active-low reset
//   in_valid / in_ready         upstream op handshake
//   mxpc_out, alu_result, imm   candidate write-back values (DATA_W)
//   uc_S_MXRB                   result select (00 ALU, 01 mem, 10 PC, 11 imm)
//   uc_W_RF, uc_W_FL, rd_addr   register write req, flag mask {O,S,C,Z}, dest
//   alu_O/S/C/Z                 ALU flags
//   dm_valid, dm_Q              data-memory response
//   rf_we, rf_waddr, mxrb_out   register-file write port
//   rf_O/S/C/Z                  architectural flags
//   busy                        FSM not in IDLE (state observation)
//   err_timeout                 sticky memory-timeout error
//   fwd_valid/addr/data         forwarding copy of the write port
//                               (present only when WB_PIPE_FWD_EN is defined)
//
// Configuration macro: WB_PIPE_FWD_EN
// -----------------------------------------------------------------------------
module wb_pipe
    import wb_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 4,
    parameter int TIMEOUT  = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] mxpc_out,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] imm,
    input  logic [1:0]        uc_S_MXRB,
    input  logic              uc_W_RF,
    input  logic [3:0]        uc_W_FL,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              alu_O,
    input  logic              alu_S,
    input  logic              alu_C,
    input  logic              alu_Z,
    input  logic              dm_valid,
    input  logic [DATA_W-1:0] dm_Q,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] mxrb_out,
    output logic              rf_O,
    output logic              rf_S,
    output logic              rf_C,
    output logic              rf_Z,
    output logic              busy,
    output logic              err_timeout
`ifdef WB_PIPE_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    // Captured op fields (pipeline register).
    logic              wrf_q, wrf_d;
    logic [3:0]        wfl_q, wfl_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [3:0]        aflags_q, aflags_d;

    // Write-port registers; loaded only on entry to COMMIT so they keep the
    // last committed values while a load is waiting on memory.
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] mxrb_q, mxrb_d;

    logic              accept;
    logic [DATA_W-1:0] sel_data;
    logic [3:0]        flags;

    assign in_ready = (state_q != ST_WAIT_MEM);
    assign accept   = in_valid & in_ready;

    // Non-load result selection, done at accept time.
    always_comb begin
        sel_data = alu_result;
        case (uc_S_MXRB)
            SEL_PC:  sel_data = mxpc_out;
            SEL_IMM: sel_data = imm;
            default: sel_data = alu_result;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        wrf_d    = wrf_q;
        wfl_d    = wfl_q;
        rd_d     = rd_q;
        aflags_d = aflags_q;
        waddr_d  = waddr_q;
        mxrb_d   = mxrb_q;

        case (state_q)
            ST_IDLE, ST_COMMIT: begin
                if (accept) begin
                    wrf_d    = uc_W_RF;
                    wfl_d    = uc_W_FL;
                    rd_d     = rd_addr;
                    aflags_d = pack_flags(alu_O, alu_S, alu_C, alu_Z);
                    if (uc_S_MXRB == SEL_MEM) begin
                        state_d = ST_WAIT_MEM;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_COMMIT;
                        waddr_d = rd_addr;
                        mxrb_d  = sel_data;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                // A response in the last allowed cycle still wins over timeout.
                if (dm_valid) begin
                    state_d = ST_COMMIT;
                    waddr_d = rd_q;
                    mxrb_d  = dm_Q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wrf_q    <= 1'b0;
            wfl_q    <= '0;
            rd_q     <= '0;
            aflags_q <= '0;
            waddr_q  <= '0;
            mxrb_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            wrf_q    <= wrf_d;
            wfl_q    <= wfl_d;
            rd_q     <= rd_d;
            aflags_q <= aflags_d;
            waddr_q  <= waddr_d;
            mxrb_q   <= mxrb_d;
        end
    end

    // Flags take effect on the edge that ends COMMIT.
    wb_flag_reg u_flag_reg (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .we_i   (state_q == ST_COMMIT),
        .mask_i (wfl_q),
        .d_i    (aflags_q),
        .q_o    (flags)
    );

    assign rf_we       = (state_q == ST_COMMIT) && wrf_q &&
                         !((ZERO_REG != 0) && (rd_q == '0));
    assign rf_waddr    = waddr_q;
    assign mxrb_out    = mxrb_q;
    assign rf_O        = flags[FLAG_O];
    assign rf_S        = flags[FLAG_S];
    assign rf_C        = flags[FLAG_C];
    assign rf_Z        = flags[FLAG_Z];
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_q;

`ifdef WB_PIPE_FWD_EN
    assign fwd_valid = rf_we;
    assign fwd_addr  = waddr_q;
    assign fwd_data  = mxrb_q;
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_pipe
// Directed bench for wb_pipe. Expected register writes are pushed into exp_q
// when an op is issued; a negedge monitor pops and compares on every rf_we.
// Handshake, flag, timeout and reset behaviour are checked inline.
// -----------------------------------------------------------------------------
module tb_wb_pipe;
  import wb_pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int EXP_W  = REG_AW + DATA_W;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] mxpc_out = '0;
  logic [DATA_W-1:0] alu_result = '0;
  logic [DATA_W-1:0] imm = '0;
  logic [1:0]        uc_S_MXRB = '0;
  logic              uc_W_RF = 1'b0;
  logic [3:0]        uc_W_FL = '0;
  logic [REG_AW-1:0] rd_addr = '0;
  logic              alu_O = 1'b0;
  logic              alu_S = 1'b0;
  logic              alu_C = 1'b0;
  logic              alu_Z = 1'b0;
  logic              dm_valid = 1'b0;
  logic [DATA_W-1:0] dm_Q = '0;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] mxrb_out;
  logic              rf_O, rf_S, rf_C, rf_Z;
  logic              busy;
  logic              err_timeout;
`ifdef WB_PIPE_FWD_EN
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_addr;
  logic [DATA_W-1:0] fwd_data;
`endif

  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  wb_pipe #(
    .DATA_W   (DATA_W),
    .REG_AW   (REG_AW),
    .TIMEOUT  (16),
    .ZERO_REG (1)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mxpc_out    (mxpc_out),
    .alu_result  (alu_result),
    .imm         (imm),
    .uc_S_MXRB   (uc_S_MXRB),
    .uc_W_RF     (uc_W_RF),
    .uc_W_FL     (uc_W_FL),
    .rd_addr     (rd_addr),
    .alu_O       (alu_O),
    .alu_S       (alu_S),
    .alu_C       (alu_C),
    .alu_Z       (alu_Z),
    .dm_valid    (dm_valid),
    .dm_Q        (dm_Q),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .mxrb_out    (mxrb_out),
    .rf_O        (rf_O),
    .rf_S        (rf_S),
    .rf_C        (rf_C),
    .rf_Z        (rf_Z),
    .busy        (busy),
    .err_timeout (err_timeout)
`ifdef WB_PIPE_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [REG_AW-1:0] addr, input logic [DATA_W-1:0] data);
    exp_q.push_back({addr, data});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                 rf_waddr, mxrb_out);
      end else begin
        check("commit_write", {rf_waddr, mxrb_out}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Present one op, hold it until accepted, return in the cycle after accept.
  task automatic send(input logic [1:0] sel, input logic wrf, input logic [3:0] wfl,
                      input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] alu,
                      input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] im,
                      input logic [3:0] fl);
    int n;
    n = 0;
    uc_S_MXRB  = sel;
    uc_W_RF    = wrf;
    uc_W_FL    = wfl;
    rd_addr    = rd;
    alu_result = alu;
    mxpc_out   = pc;
    imm        = im;
    {alu_O, alu_S, alu_C, alu_Z} = fl;
    in_valid   = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check("send_ready", in_ready, 1'b1);
    tick(1);
    in_valid = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 RST_N = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_waddr_data", {rf_waddr, mxrb_out}, '0);
    check("rst_flags", {rf_O, rf_S, rf_C, rf_Z}, 4'b0000);
    check("rst_err", err_timeout, 1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // ALU op, one-cycle latency to rf_we.
    expect_wr(4'd5, 32'h0000_00AA);
    send(SEL_ALU, 1'b1, 4'b0000, 4'd5, 32'h0000_00AA, 32'h0000_0100, 32'h0000_0055, 4'b0000);
    check("alu_we_latency", rf_we, 1'b1);
    check("alu_busy", busy, 1'b1);
    tick(1);
    check("alu_we_after", rf_we, 1'b0);
    check("alu_hold", {rf_waddr, mxrb_out}, {4'd5, 32'h0000_00AA});
    check("alu_idle", busy, 1'b0);

    // PC and immediate selects back to back.
    expect_wr(4'd3, 32'h0000_1234);
    expect_wr(4'd7, 32'h0000_CAFE);
    send(SEL_PC,  1'b1, 4'b0000, 4'd3, 32'h0000_0001, 32'h0000_1234, 32'h0000_0007, 4'b0000);
    send(SEL_IMM, 1'b1, 4'b0000, 4'd7, 32'h0000_0002, 32'h0000_0004, 32'h0000_CAFE, 4'b0000);
    tick(1);

    // Masked flag updates.
    send(SEL_ALU, 1'b0, 4'b0101, 4'd1, 32'h0, 32'h0, 32'h0, 4'b1111);
    check("flags_before_edge", {rf_O, rf_S, rf_C, rf_Z}, 4'b0000);
    tick(1);
    check("flags_mask_0101", {rf_O, rf_S, rf_C, rf_Z}, 4'b0101);
    send(SEL_ALU, 1'b0, 4'b1000, 4'd1, 32'h0, 32'h0, 32'h0, 4'b1111);
    tick(1);
    check("flags_mask_1000", {rf_O, rf_S, rf_C, rf_Z}, 4'b1101);
    send(SEL_ALU, 1'b0, 4'b0001, 4'd1, 32'h0, 32'h0, 32'h0, 4'b0000);
    tick(1);
    check("flags_mask_0001", {rf_O, rf_S, rf_C, rf_Z}, 4'b1100);

    // Stray memory strobe while idle is ignored.
    dm_valid = 1'b1;
    dm_Q     = 32'h1234_5678;
    tick(1);
    dm_valid = 1'b0;
    check("idle_dm_ignored", busy, 1'b0);

    // Load answered in the third wait cycle.
    expect_wr(4'd9, 32'hDEAD_BEEF);
    send(SEL_MEM, 1'b1, 4'b0000, 4'd9, 32'h0000_0011, 32'h0, 32'h0, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      check("load_wait_ready", in_ready, 1'b0);
      if (i == 2) begin
        dm_valid = 1'b1;
        dm_Q     = 32'hDEAD_BEEF;
      end
      tick(1);
    end
    dm_valid = 1'b0;
    check("load_commit_we", rf_we, 1'b1);
    check("load_commit_ready", in_ready, 1'b1);
    tick(1);

    // Load with no response: timeout after 16 wait cycles, op dropped.
    send(SEL_MEM, 1'b1, 4'b1111, 4'd4, 32'h0, 32'h0, 32'h0, 4'b0011);
    for (int i = 0; i < 16; i++) begin
      check("timeout_wait_ready", in_ready, 1'b0);
      tick(1);
    end
    check("timeout_ready", in_ready, 1'b1);
    check("timeout_err", err_timeout, 1'b1);
    check("timeout_idle", busy, 1'b0);
    check("timeout_flags_kept", {rf_O, rf_S, rf_C, rf_Z}, 4'b1100);
    tick(2);
    check("timeout_err_sticky", err_timeout, 1'b1);

    // Back-to-back ALU ops to rd 0/1/2; write to r0 suppressed.
    expect_wr(4'd1, 32'h0000_0101);
    expect_wr(4'd2, 32'h0000_0102);
    send(SEL_ALU, 1'b1, 4'b0000, 4'd0, 32'h0000_0100, 32'h0, 32'h0, 4'b0000);
    check("b2b_we_rd0", rf_we, 1'b0);
    send(SEL_ALU, 1'b1, 4'b0000, 4'd1, 32'h0000_0101, 32'h0, 32'h0, 4'b0000);
    check("b2b_we_rd1", rf_we, 1'b1);
    send(SEL_ALU, 1'b1, 4'b0000, 4'd2, 32'h0000_0102, 32'h0, 32'h0, 4'b0000);
    check("b2b_we_rd2", rf_we, 1'b1);
    tick(1);
    check("b2b_we_end", rf_we, 1'b0);
    check("b2b_err_sticky", err_timeout, 1'b1);

    // Reset while waiting on memory; late response must not write.
    send(SEL_MEM, 1'b1, 4'b1111, 4'd6, 32'h0, 32'h0, 32'h0, 4'b1111);
    tick(1);
    RST_N = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_flags", {rf_O, rf_S, rf_C, rf_Z}, 4'b0000);
    check("midrst_err", err_timeout, 1'b0);
    check("midrst_out", {rf_waddr, mxrb_out}, '0);
    tick(1);
    RST_N = 1'b1;
    check("midrst_ready_after", in_ready, 1'b1);
    dm_valid = 1'b1;
    dm_Q     = 32'h0BAD_C0DE;
    tick(1);
    dm_valid = 1'b0;
    check("midrst_no_we", rf_we, 1'b0);
    check("midrst_idle", busy, 1'b0);
    check("midrst_flags_after", {rf_O, rf_S, rf_C, rf_Z}, 4'b0000);
    tick(2);

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
